// File: rtl/qgemm_pkg.sv
// Shared helpers for the qgemm result path: sizing functions and the
// row-width divisibility check used at elaboration.
package qgemm_pkg;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v = value - 1;
    while (v > 0) begin
      res++;
      v = v >> 1;
    end
    return res;
  endfunction

  function automatic int beats_per_row(input int lanes, input int fp_w, input int out_w);
    return (lanes * fp_w) / out_w;
  endfunction

  function automatic bit row_width_ok(input int lanes, input int fp_w, input int out_w);
    return (out_w > 0) && (((lanes * fp_w) % out_w) == 0);
  endfunction

endpackage

// File: rtl/dq_row_fifo.sv
// Small show-ahead row FIFO between the dequantizer and the beat serializer.
// The caller guarantees push only when not full and pop only when not empty.
module dq_row_fifo
  import qgemm_pkg::*;
#(
  parameter int WIDTH = 512,
  parameter int DEPTH = 2,
  localparam int CNT_W = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstnn,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (push_i) wr_d = (wr_q == LAST_PTR) ? '0 : wr_q + 1'b1;
    if (pop_i)  rd_d = (rd_q == LAST_PTR) ? '0 : rd_q + 1'b1;
    if (push_i && !pop_i)      cnt_d = cnt_q + 1'b1;
    else if (!push_i && pop_i) cnt_d = cnt_q - 1'b1;
    if (clear_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/dq_row_writer.sv
// Receives dequantized FP32 rows, checks the row-index sequence and
// serializes each row into OUT_W-bit beats, flagging the last beat of a tile.
module dq_row_writer
  import qgemm_pkg::*;
#(
  parameter int FP_DATA_W  = 32,
  parameter int LANES_NUM  = 16,
  parameter int MAT_SIZE   = 16,
  parameter int ROW_W_DQ   = 4,
  parameter int OUT_W      = 128,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rstnn,
  input  logic                          start_i,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  input  logic [LANES_NUM*FP_DATA_W-1:0] s_data_i,
  input  logic [ROW_W_DQ-1:0]           s_index_i,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [OUT_W-1:0]              m_data_o,
  output logic                          m_last_o,
  output logic                          tile_done_o,
  output logic                          err_idx_o,
  output logic                          busy_o
);

  localparam int ROW_W  = LANES_NUM * FP_DATA_W;
  localparam int BEATS  = beats_per_row(LANES_NUM, FP_DATA_W, OUT_W);
  localparam int BEAT_W = (clog2(BEATS) > 0) ? clog2(BEATS) : 1;
  localparam int OROW_W = (clog2(MAT_SIZE) > 0) ? clog2(MAT_SIZE) : 1;
  localparam int CNT_W  = clog2(FIFO_DEPTH + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [OROW_W-1:0] LAST_ROW  = OROW_W'(MAT_SIZE - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

  if (!row_width_ok(LANES_NUM, FP_DATA_W, OUT_W)) begin : g_bad_out_w
    $error("dq_row_writer: OUT_W must divide LANES_NUM*FP_DATA_W");
  end

  logic                run_q;
  logic [ROW_W_DQ-1:0] exp_row_q, exp_row_d;
  logic                err_q, err_d;
  logic [ROW_W-1:0]    sh_q, sh_d;
  logic                sh_valid_q, sh_valid_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [OROW_W-1:0]   out_row_q, out_row_d;
  logic                done_q, done_d;

  logic [ROW_W-1:0] fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic push, load, fire, last_beat, tile_last;

  // run_q keeps s_ready_o low while reset is asserted.
  assign s_ready_o = run_q && !start_i && (fifo_count < DEPTH_C);
  assign push      = s_valid_i && s_ready_o;
  assign fire      = sh_valid_q && m_ready_i;
  assign last_beat = (beat_cnt_q == LAST_BEAT);
  assign tile_last = sh_valid_q && last_beat && (out_row_q == LAST_ROW);
  assign load      = (!sh_valid_q || (fire && last_beat)) && (fifo_count != '0) && !start_i;

  dq_row_fifo #(
    .WIDTH (ROW_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstnn   (rstnn),
    .clear_i (start_i),
    .push_i  (push),
    .data_i  (s_data_i),
    .pop_i   (load),
    .head_o  (fifo_head),
    .count_o (fifo_count)
  );

  always_comb begin
    exp_row_d  = exp_row_q;
    err_d      = err_q;
    sh_d       = sh_q;
    sh_valid_d = sh_valid_q;
    beat_cnt_d = beat_cnt_q;
    out_row_d  = out_row_q;
    done_d     = fire && tile_last;

    if (push) begin
      if (s_index_i != exp_row_q) err_d = 1'b1;
      exp_row_d = exp_row_q + 1'b1;
    end

    if (fire) begin
      if (last_beat) begin
        beat_cnt_d = '0;
        out_row_d  = (out_row_q == LAST_ROW) ? '0 : out_row_q + 1'b1;
        sh_valid_d = 1'b0;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
        sh_d       = sh_q >> OUT_W;
      end
    end

    // A load on the final beat refills the register with no bubble.
    if (load) begin
      sh_d       = fifo_head;
      sh_valid_d = 1'b1;
    end

    if (start_i) begin
      exp_row_d  = '0;
      err_d      = 1'b0;
      sh_d       = '0;
      sh_valid_d = 1'b0;
      beat_cnt_d = '0;
      out_row_d  = '0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      run_q      <= 1'b0;
      exp_row_q  <= '0;
      err_q      <= 1'b0;
      sh_q       <= '0;
      sh_valid_q <= 1'b0;
      beat_cnt_q <= '0;
      out_row_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      exp_row_q  <= exp_row_d;
      err_q      <= err_d;
      sh_q       <= sh_d;
      sh_valid_q <= sh_valid_d;
      beat_cnt_q <= beat_cnt_d;
      out_row_q  <= out_row_d;
      done_q     <= done_d;
    end
  end

  assign m_valid_o   = sh_valid_q;
  assign m_data_o    = sh_q[OUT_W-1:0];
  assign m_last_o    = tile_last;
  assign tile_done_o = done_q;
  assign err_idx_o   = err_q;
  assign busy_o      = sh_valid_q || (fifo_count != '0);

endmodule

// File: tb/tb_dq_row_writer.sv
// Directed bench for dq_row_writer: rows are pushed with a reference beat
// queue, and a negedge monitor compares every offered beat against it.
module tb_dq_row_writer;

  localparam int ROW_W = 512;
  localparam int OUT_W = 128;
  localparam int BEATS = 4;
  localparam int MAT   = 16;

  logic             clk = 1'b0;
  logic             rstnn = 1'b0;
  logic             start_i = 1'b0;
  logic             s_valid_i = 1'b0;
  logic             s_ready_o;
  logic [ROW_W-1:0] s_data_i = '0;
  logic [3:0]       s_index_i = '0;
  logic             m_valid_o;
  logic             m_ready_i = 1'b0;
  logic [OUT_W-1:0] m_data_o;
  logic             m_last_o;
  logic             tile_done_o;
  logic             err_idx_o;
  logic             busy_o;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             last;
  } beat_t;

  beat_t sbq[$];
  int total = 0;
  int bad = 0;
  int readyMode = 0;
  int acceptedCount = 0;
  int lastCount = 0;
  int tdCount = 0;
  int cycleCnt = 0;
  int firstAccept = -1;
  int lastAccept = -1;
  int outRowModel = 0;
  logic errExp = 1'b0;
  logic tdPending = 1'b0;
  logic [3:0] expRow = '0;

  dq_row_writer dut (
    .clk         (clk),
    .rstnn       (rstnn),
    .start_i     (start_i),
    .s_valid_i   (s_valid_i),
    .s_ready_o   (s_ready_o),
    .s_data_i    (s_data_i),
    .s_index_i   (s_index_i),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .m_data_o    (m_data_o),
    .m_last_o    (m_last_o),
    .tile_done_o (tile_done_o),
    .err_idx_o   (err_idx_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Sink ready: 0 = always ready, 1 = stalling pattern, 2 = never ready.
  initial begin
    logic [3:0] pat;
    int k;
    pat = 4'b1001;
    k = 0;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0: m_ready_i = 1'b1;
        1: m_ready_i = ((k % 8) < 4) ? pat[k % 4] : 1'($urandom_range(0, 1));
        default: m_ready_i = 1'b0;
      endcase
      k++;
    end
  end

  always @(negedge clk) begin : monitor
    logic nextTd;
    beat_t head;
    if (!rstnn) begin
      tdPending = 1'b0;
    end else begin
      checkOutput("tile_done", tile_done_o, tdPending);
      if (tile_done_o) tdCount++;
      checkOutput("err_idx", err_idx_o, errExp);
      nextTd = 1'b0;
      if (m_valid_o) begin
        if (sbq.size() == 0) begin
          checkOutput("unexpected_beat", m_valid_o, 1'b0);
        end else begin
          checkOutput("beat_data", m_data_o, sbq[0].data);
          checkOutput("beat_last", m_last_o, sbq[0].last);
          if (m_ready_i && !start_i) begin
            head = sbq.pop_front();
            nextTd = head.last;
            if (head.last) lastCount++;
            acceptedCount++;
            if (firstAccept < 0) firstAccept = cycleCnt;
            lastAccept = cycleCnt;
          end
        end
      end else begin
        checkOutput("m_last_idle", m_last_o, 1'b0);
      end
      tdPending = nextTd;
    end
  end

  task automatic applyStimulus(input int rowTag, input logic [3:0] idx);
    logic [ROW_W-1:0] row;
    int waitCnt;
    for (int l = 0; l < 16; l++) row[l*32 +: 32] = {16'(rowTag), 16'(l)};
    s_data_i  = row;
    s_index_i = idx;
    s_valid_i = 1'b1;
    waitCnt = 0;
    @(negedge clk);
    while (!s_ready_o && waitCnt < 300) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!s_ready_o) begin
      checkOutput("s_ready_wait", s_ready_o, 1'b1);
      @(posedge clk);
      #1;
      s_valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    s_valid_i = 1'b0;
    if (idx != expRow) errExp = 1'b1;
    expRow = expRow + 4'd1;
    for (int k = 0; k < BEATS; k++) begin
      beat_t b;
      b.data = row[k*OUT_W +: OUT_W];
      b.last = (outRowModel == MAT - 1) && (k == BEATS - 1);
      sbq.push_back(b);
    end
    outRowModel = (outRowModel + 1) % MAT;
  endtask

  task automatic startTile();
    start_i = 1'b1;
    @(negedge clk);
    checkOutput("start_s_ready", s_ready_o, 1'b0);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    sbq.delete();
    expRow = '0;
    outRowModel = 0;
    errExp = 1'b0;
  endtask

  task automatic runTile(input int tagBase);
    for (int r = 0; r < 16; r++) applyStimulus(tagBase + r, 4'(r));
  endtask

  task automatic waitDrain();
    int cnt;
    cnt = 0;
    while (sbq.size() != 0 && cnt < 3000) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    if (sbq.size() != 0) checkOutput("drain_timeout", sbq.size(), 0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int td0;
    int lc0;
    int base;
    int w;

    $display("[TB] reset values");
    repeat (2) @(negedge clk);
    checkOutput("rst_m_valid", m_valid_o, 1'b0);
    checkOutput("rst_s_ready", s_ready_o, 1'b0);
    checkOutput("rst_m_last", m_last_o, 1'b0);
    checkOutput("rst_tile_done", tile_done_o, 1'b0);
    checkOutput("rst_err", err_idx_o, 1'b0);
    checkOutput("rst_busy", busy_o, 1'b0);
    checkOutput("rst_m_data", m_data_o, '0);
    @(posedge clk);
    #3;
    rstnn = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] scenario 1: one tile, full rate");
    readyMode = 0;
    startTile();
    td0 = tdCount;
    lc0 = lastCount;
    runTile(0);
    waitDrain();
    checkOutput("t1_tile_done_cnt", tdCount - td0, 1);
    checkOutput("t1_last_cnt", lastCount - lc0, 1);
    checkOutput("t1_busy_idle", busy_o, 1'b0);

    $display("[TB] scenario 2: stalling sink");
    readyMode = 1;
    startTile();
    td0 = tdCount;
    runTile(0);
    waitDrain();
    checkOutput("t2_tile_done_cnt", tdCount - td0, 1);

    $display("[TB] scenario 3: index error");
    readyMode = 0;
    startTile();
    for (int r = 0; r < 16; r++) applyStimulus(300 + r, (r < 2) ? 4'(r) : 4'(r + 1));
    waitDrain();
    checkOutput("t3_err_sticky", err_idx_o, 1'b1);
    startTile();
    @(negedge clk);
    checkOutput("t3_err_cleared", err_idx_o, 1'b0);
    @(posedge clk);
    #1;

    $display("[TB] scenario 4: two tiles back to back");
    td0 = tdCount;
    lc0 = lastCount;
    firstAccept = -1;
    for (int r = 0; r < 32; r++) applyStimulus(100 + r, 4'(r % 16));
    waitDrain();
    checkOutput("t4_span", lastAccept - firstAccept, 127);
    checkOutput("t4_tile_done_cnt", tdCount - td0, 2);
    checkOutput("t4_last_cnt", lastCount - lc0, 2);

    $display("[TB] scenario 5: start mid tile");
    startTile();
    base = acceptedCount;
    for (int r = 0; r < 6; r++) applyStimulus(400 + r, 4'(r));
    w = 0;
    while ((acceptedCount - base) != 22 && w < 500) begin
      @(posedge clk);
      #1;
      w++;
    end
    checkOutput("t5_reach_beat", acceptedCount - base, 22);
    startTile();
    @(negedge clk);
    checkOutput("t5_m_valid", m_valid_o, 1'b0);
    checkOutput("t5_busy", busy_o, 1'b0);
    checkOutput("t5_s_ready", s_ready_o, 1'b1);
    @(posedge clk);
    #1;
    td0 = tdCount;
    runTile(500);
    waitDrain();
    checkOutput("t5_tile_done_cnt", tdCount - td0, 1);

    $display("[TB] scenario 6: reset during stall");
    readyMode = 2;
    startTile();
    for (int r = 0; r < 3; r++) applyStimulus(600 + r, 4'(r));
    @(negedge clk);
    checkOutput("t6_s_ready_full", s_ready_o, 1'b0);
    checkOutput("t6_busy", busy_o, 1'b1);
    checkOutput("t6_stalled_valid", m_valid_o, 1'b1);
    repeat (3) @(negedge clk);
    #2;
    rstnn = 1'b0;
    #1;
    checkOutput("t6_async_m_valid", m_valid_o, 1'b0);
    checkOutput("t6_async_s_ready", s_ready_o, 1'b0);
    checkOutput("t6_async_m_data", m_data_o, '0);
    checkOutput("t6_async_busy", busy_o, 1'b0);
    checkOutput("t6_async_m_last", m_last_o, 1'b0);
    sbq.delete();
    expRow = '0;
    outRowModel = 0;
    errExp = 1'b0;
    @(posedge clk);
    #3;
    rstnn = 1'b1;
    readyMode = 0;
    @(posedge clk);
    #1;
    startTile();
    td0 = tdCount;
    lc0 = lastCount;
    runTile(0);
    waitDrain();
    checkOutput("t6_tile_done_cnt", tdCount - td0, 1);
    checkOutput("t6_last_cnt", lastCount - lc0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

endmodule
